mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU (and MADD family) in cycles, legal range 1..15.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request qualifying op/rs_data/rt_data.
REQ-006 SHALL have port op  input  3  operation code from shared package (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MSUB).
REQ-007 SHALL have port rs_data  input  32  first operand; source for MTHI/MTLO.
REQ-008 SHALL have port rt_data  input  32  second operand.
REQ-009 SHALL have port busy  output  1  registered; high while an operation is in flight; drives the hazard unit's MD stall input.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.

Function
REQ-012 SHALL implement two states, IDLE and RUN, with a 4-bit down-counter.
REQ-013 IDLE + start + op in {MULT, MULTU, MADD, MSUB}: SHALL capture operands, load counter with MULT_CYCLES, go to RUN.
REQ-014 IDLE + start + op in {DIV, DIVU}: SHALL capture operands, load counter with DIV_CYCLES, go to RUN.
REQ-015 busy SHALL be high exactly N cycles, starting the cycle after the start edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 In RUN, counter SHALL decrement each cycle; at the edge where it reaches 0, SHALL write hi/lo and return to IDLE; busy low and new hi/lo visible in the same cycle.
REQ-017 hi/lo SHALL hold old values throughout RUN.
REQ-018 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder carrying dividend's sign; DIVU: unsigned quotient/remainder.
REQ-020 Divide by zero: SHALL still run DIV_CYCLES with busy high, and leave hi/lo unchanged.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-022 IDLE + start + MTHI/MTLO: SHALL write rs_data to hi (or lo) at the next edge, no busy, state stays IDLE.
REQ-023 start while in RUN (any op) SHALL be ignored, no state or output change.
REQ-024 start with an undefined op code SHALL be ignored.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, counter 0, busy 0, hi 0, lo 0, regardless of clock.
REQ-026 Reset during RUN SHALL abandon the operation; no result is ever committed.
REQ-027 First start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro MD_MADD_EN SHALL gate MADD/MSUB support.
REQ-029 With MD_MADD_EN defined: MADD sets {hi,lo} = {hi,lo} + signed(rs*rt), MSUB sets {hi,lo} = {hi,lo} - signed(rs*rt), modulo 2^64, MULT_CYCLES latency, using hi/lo sampled at commit.
REQ-030 Without MD_MADD_EN: MADD/MSUB codes SHALL be treated as undefined per REQ-024, and no accumulate adder is synthesised.

Structure
REQ-031 Op encodings, 4-bit counter width, and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared instruction-definitions package, also used by the decode/hazard logic.
REQ-032 Arithmetic SHALL sit in one combinational sub-module md_arith (operands, op -> 64-bit result plus div-by-zero flag); mult_div_unit holds the FSM, counter, operand/result registers, and hi/lo.

Verification
REQ-033 MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
REQ-035 MTHI rs=0x12345678 while IDLE -> hi=0x12345678 the next cycle, busy never high; MTLO issued during a running DIV -> ignored, lo gets the DIV result.
REQ-036 reset_n pulsed low in cycle 3 of a MULT -> busy, hi, lo all 0 immediately; no commit afterwards; a new MULT on the first edge after reset completes normally.
REQ-037 MD_MADD_EN defined, hi=0, lo=1, MSUB rs=1, rt=2 -> after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFF; macro undefined, same stimulus -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared instruction definitions for the multiply/divide unit: op encodings,
// counter width and default latencies. MD_MADD_EN enables MADD/MSUB.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5,
        MD_OP_MADD  = 3'd6,
        MD_OP_MSUB  = 3'd7
    } md_op_e;

    localparam int MD_CNT_W            = 4;
    localparam int MD_MULT_CYCLES_DEF  = 5;
    localparam int MD_DIV_CYCLES_DEF   = 10;

    function automatic logic md_is_mult_op(input md_op_e op);
        case (op)
            MD_OP_MULT, MD_OP_MULTU: return 1'b1;
`ifdef MD_MADD_EN
            MD_OP_MADD, MD_OP_MSUB:  return 1'b1;
`endif
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div_op(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational multiply/divide datapath: {hi,lo} result and divide-by-zero flag.
// The accumulate input and adder exist only when MD_MADD_EN is defined.
module md_arith
    import mult_div_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
`ifdef MD_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] divisor;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot;
    logic [31:0] rem;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN naturally.
    assign rs_neg  = (op == MD_OP_DIV) && rs_data[31];
    assign rt_neg  = (op == MD_OP_DIV) && rt_data[31];
    assign abs_rs  = rs_neg ? -rs_data : rs_data;
    assign abs_rt  = rt_neg ? -rt_data : rt_data;
    assign divisor = (rt_data == 32'd0) ? 32'd1 : abs_rt;
    assign quot_u  = abs_rs / divisor;
    assign rem_u   = abs_rs % divisor;
    assign quot    = (rs_neg ^ rt_neg) ? -quot_u : quot_u;
    assign rem     = rs_neg ? -rem_u : rem_u;

    assign div_by_zero = md_is_div_op(op) && (rt_data == 32'd0);

    // NOTE: assign a default first so every path drives result and no latch is inferred.
    always_comb begin
        result = '0;
        case (op)
            MD_OP_MULT:  result = prod_s;
            MD_OP_MULTU: result = prod_u;
            MD_OP_DIV,
            MD_OP_DIVU:  result = {rem, quot};
`ifdef MD_MADD_EN
            MD_OP_MADD:  result = acc + prod_s;
            MD_OP_MSUB:  result = acc - prod_s;
`endif
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MD_MADD_EN to accept MADD/MSUB accumulate operations.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
    localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

    state_e              state, state_next;
    logic [MD_CNT_W-1:0] count, count_next;
    md_op_e              op_in;
    md_op_e              op_q;
    logic [31:0]         rs_q;
    logic [31:0]         rt_q;
    logic                capture;
    logic                commit;
    logic                mthi_wr;
    logic                mtlo_wr;
    logic [63:0]         result;
    logic                div_by_zero;

    assign op_in = md_op_e'(op);

    md_arith u_md_arith (
        .op          (op_q),
        .rs_data     (rs_q),
        .rt_data     (rt_q),
`ifdef MD_MADD_EN
        .acc         ({hi, lo}),
`endif
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        commit     = 1'b0;
        mthi_wr    = 1'b0;
        mtlo_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (md_is_mult_op(op_in)) begin
                        capture    = 1'b1;
                        count_next = MULT_LOAD;
                        state_next = RUN;
                    end else if (md_is_div_op(op_in)) begin
                        capture    = 1'b1;
                        count_next = DIV_LOAD;
                        state_next = RUN;
                    end else if (op_in == MD_OP_MTHI) begin
                        mthi_wr = 1'b1;
                    end else if (op_in == MD_OP_MTLO) begin
                        mtlo_wr = 1'b1;
                    end
                end
            end
            RUN: begin
                count_next = count - CNT_ONE;
                if (count == CNT_ONE) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            busy  <= (state_next == RUN);
        end
    end

    // NOTE: operand registers are reset too, keeping the arithmetic inputs defined after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= MD_OP_MULT;
            rs_q <= '0;
            rt_q <= '0;
        end else if (capture) begin
            op_q <= op_in;
            rs_q <= rs_data;
            rt_q <= rt_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (commit && !div_by_zero) begin
            hi <= result[63:32];
            lo <= result[31:0];
        end else if (mthi_wr) begin
            hi <= rs_data;
        end else if (mtlo_wr) begin
            lo <= rs_data;
        end
    end

endmodule
